// File: rtl/pcie_rb_pkg.sv
// Types and defaults local to the PCIe ring-buffer responder.
package pcie_rb_pkg;

  localparam int RB_AWIDTH_DFLT = 12;

  typedef enum logic {
    IDLE,
    STREAM
  } rb_state_t;

  typedef logic [RB_AWIDTH_DFLT:0] rb_ptr_t;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
  } rb_beat_t;

endpackage

// File: rtl/struct_s.sv
// Shared transport types used by the PCIe ring-buffer interfaces.
package struct_s;

  localparam int PDU_AWIDTH = 16;

  typedef struct packed {
    logic [511:0] data;
  } flit_lite_t;

endpackage

// File: rtl/pcie_rb_ram.sv
// Simple dual-port ring storage: one write port, one read port with a registered read.
module pcie_rb_ram #(
    parameter int AW    = 12,
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/unified_fifo.sv
// Synchronous FIFO with show-ahead read data and an occupancy count.
module unified_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pcie_rb_responder.sv
// Ring-buffer responder: stores DMA flits, commits PDUs by size and drains them as an
// SOP/EOP stream through a 2-entry skid buffer at the host port.
module pcie_rb_responder
    import pcie_rb_pkg::*;
    import struct_s::*;
#(
    parameter int RB_AWIDTH       = RB_AWIDTH_DFLT,
    parameter int AF_THRESH       = 32,
    parameter int SIZE_FIFO_DEPTH = 64
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  flit_lite_t            pcie_rb_wr_data,
    input  logic [PDU_AWIDTH-1:0] pcie_rb_wr_addr,
    input  logic                  pcie_rb_wr_en,
    output logic [PDU_AWIDTH-1:0] pcie_rb_wr_base_addr,
    output logic                  pcie_rb_almost_full,
    input  logic                  pcie_rb_update_valid,
    input  logic [PDU_AWIDTH-1:0] pcie_rb_update_size,
    output logic [511:0]          host_data,
    output logic                  host_sop,
    output logic                  host_eop,
    output logic                  host_valid,
    input  logic                  host_ready,
    output logic [31:0]           rb_pdu_cnt,
    output logic [31:0]           rb_err_cnt
);

    localparam int PW    = RB_AWIDTH + 1;
    localparam int DEPTH = 1 << RB_AWIDTH;
    localparam int FCW   = $clog2(SIZE_FIFO_DEPTH + 1);

    rb_state_t             state_q, state_d;
    logic [PW-1:0]         tail_q, tail_d, head_q, head_d, used, free;
    logic [RB_AWIDTH-1:0]  wr_off;
    logic [PDU_AWIDTH-1:0] rem_q, rem_d, fifo_dout;
    logic [FCW-1:0]        fifo_cnt;
    logic [511:0]          ram_rdata;
    logic [31:0]           pdu_cnt_q, pdu_cnt_d, err_cnt_q, err_cnt_d;
    logic [2:0]            occ_next;
    logic [1:0]            skid_cnt_q, skid_cnt_d;
    rb_beat_t [1:0]        skid_q, skid_d;
    rb_beat_t              in_beat, out_beat;
    logic first_q, first_d, rd_valid_q, rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;
    logic af_q, af_d, wr_ok, wr_rej, upd_nz, upd_rej, upd_ok;
    logic fifo_pop, fifo_full, fifo_empty, rd_en, eop_read, host_pop;
    logic unused_addr_bits;

    assign used     = tail_q - head_q;
    assign free     = PW'(DEPTH) - used;
    assign wr_off   = pcie_rb_wr_addr[RB_AWIDTH-1:0] - tail_q[RB_AWIDTH-1:0];
    assign wr_ok    = pcie_rb_wr_en && ({1'b0, wr_off} < free);
    assign wr_rej   = pcie_rb_wr_en && !wr_ok;
    assign upd_nz   = pcie_rb_update_valid && (pcie_rb_update_size != '0);
    assign upd_rej  = upd_nz && ((32'(pcie_rb_update_size) > 32'(free)) || fifo_full);
    assign upd_ok   = upd_nz && !upd_rej;
    assign unused_addr_bits = ^pcie_rb_wr_addr[PDU_AWIDTH-1:RB_AWIDTH];

    unified_fifo #(.WIDTH(PDU_AWIDTH), .DEPTH(SIZE_FIFO_DEPTH)) u_size_fifo (
        .clk(Clk), .rst_n(Rst_n), .push(upd_ok), .push_data(pcie_rb_update_size),
        .pop(fifo_pop), .pop_data(fifo_dout), .full(fifo_full), .empty(fifo_empty),
        .count(fifo_cnt)
    );

    pcie_rb_ram #(.AW(RB_AWIDTH), .WIDTH(512)) u_ram (
        .clk(Clk), .we(wr_ok), .waddr(pcie_rb_wr_addr[RB_AWIDTH-1:0]),
        .wdata(pcie_rb_wr_data.data), .re(rd_en), .raddr(head_q[RB_AWIDTH-1:0]),
        .rdata(ram_rdata)
    );

    // Host sees the oldest skid entry, or the RAM output directly when the skid is empty.
    assign in_beat    = '{data: ram_rdata, sop: rd_sop_q, eop: rd_eop_q};
    assign out_beat   = (skid_cnt_q != '0) ? skid_q[0] : in_beat;
    assign host_valid = (skid_cnt_q != '0) || rd_valid_q;
    assign host_pop   = host_valid && host_ready;
    assign host_data  = host_valid ? out_beat.data : '0;
    assign host_sop   = host_valid && out_beat.sop;
    assign host_eop   = host_valid && out_beat.eop;
    assign occ_next   = 3'(skid_cnt_q) + 3'(rd_valid_q) - 3'(host_pop);
    assign eop_read   = rd_en && (rem_q == PDU_AWIDTH'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = STREAM;
            STREAM:  if (eop_read && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en    = (state_q == STREAM) && (occ_next <= 3'd1);
        fifo_pop = 1'b0;
        rem_d    = rem_q;
        first_d  = first_q;
        head_d   = head_q;
        rd_sop_d = rd_en && first_q;
        rd_eop_d = rd_en && (rem_q == PDU_AWIDTH'(1));
        if (state_q == IDLE && !fifo_empty) begin
            fifo_pop = 1'b1;
            rem_d    = fifo_dout;
            first_d  = 1'b1;
        end
        if (rd_en) begin
            head_d  = head_q + PW'(1);
            rem_d   = rem_q - PDU_AWIDTH'(1);
            first_d = 1'b0;
            if (eop_read && !fifo_empty) begin
                fifo_pop = 1'b1;
                rem_d    = fifo_dout;
                first_d  = 1'b1;
            end
        end
    end

    always_comb begin
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        case (skid_cnt_q)
            2'd0: if (rd_valid_q && !host_pop) begin
                skid_d[0]  = in_beat;
                skid_cnt_d = 2'd1;
            end
            2'd1: if (host_pop) begin
                if (rd_valid_q) skid_d[0] = in_beat;
                else            skid_cnt_d = 2'd0;
            end else if (rd_valid_q) begin
                skid_d[1]  = in_beat;
                skid_cnt_d = 2'd2;
            end
            default: if (host_pop) begin
                skid_d[0] = skid_q[1];
                if (rd_valid_q) skid_d[1] = in_beat;
                else            skid_cnt_d = 2'd1;
            end
        endcase
    end

    always_comb begin
        tail_d    = upd_ok ? tail_q + PW'(pcie_rb_update_size) : tail_q;
        af_d      = (32'(free) <= 32'(AF_THRESH)) ||
                    ((32'(fifo_cnt) + 32'd1) >= 32'(SIZE_FIFO_DEPTH));
        pdu_cnt_d = pdu_cnt_q + 32'(host_pop && out_beat.eop);
        err_cnt_d = err_cnt_q + 32'(wr_rej) + 32'(upd_rej);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tail_q     <= '0;
            head_q     <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sop_q   <= 1'b0;
            rd_eop_q   <= 1'b0;
            skid_cnt_q <= '0;
            af_q       <= 1'b0;
            pdu_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            tail_q     <= tail_d;
            head_q     <= head_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            rd_valid_q <= rd_en;
            rd_sop_q   <= rd_sop_d;
            rd_eop_q   <= rd_eop_d;
            skid_cnt_q <= skid_cnt_d;
            af_q       <= af_d;
            pdu_cnt_q  <= pdu_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_ff @(posedge Clk) begin
        skid_q <= skid_d;
    end

    assign pcie_rb_wr_base_addr = PDU_AWIDTH'(tail_q);
    assign pcie_rb_almost_full  = af_q;
    assign rb_pdu_cnt           = pdu_cnt_q;
    assign rb_err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_pcie_rb_responder.sv
// Directed bench for pcie_rb_responder with a 16-slot ring and AF threshold of 3.
module tb_pcie_rb_responder;
    import struct_s::*;

    logic                  Clk = 1'b0;
    logic                  Rst_n = 1'b0;
    flit_lite_t            wr_data;
    logic [PDU_AWIDTH-1:0] wr_addr, base_addr, upd_size;
    logic                  wr_en, almost_full, upd_valid;
    logic [511:0]          host_data;
    logic                  host_sop, host_eop, host_valid, host_ready;
    logic [31:0]           pdu_cnt, err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] bd [32];
    logic         bs [32];
    logic         be [32];
    int           bc [32];

    pcie_rb_responder #(.RB_AWIDTH(4), .AF_THRESH(3), .SIZE_FIFO_DEPTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .pcie_rb_wr_data(wr_data), .pcie_rb_wr_addr(wr_addr), .pcie_rb_wr_en(wr_en),
        .pcie_rb_wr_base_addr(base_addr), .pcie_rb_almost_full(almost_full),
        .pcie_rb_update_valid(upd_valid), .pcie_rb_update_size(upd_size),
        .host_data(host_data), .host_sop(host_sop), .host_eop(host_eop),
        .host_valid(host_valid), .host_ready(host_ready),
        .rb_pdu_cnt(pdu_cnt), .rb_err_cnt(err_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int tag);
        return {16{32'(tag)}};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_slot(input int slot, input int tag);
        wr_en        = 1'b1;
        wr_addr      = PDU_AWIDTH'(slot);
        wr_data.data = pat(tag);
        tick();
        wr_en        = 1'b0;
    endtask

    task automatic commit(input int size);
        upd_valid = 1'b1;
        upd_size  = PDU_AWIDTH'(size);
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic commit_two_singles();
        upd_valid = 1'b1;
        upd_size  = PDU_AWIDTH'(1);
        tick();
        tick();
        upd_valid = 1'b0;
    endtask

    // mode 0: host_ready held high; mode 1: host_ready toggles starting high.
    task automatic collect(input int n, input int mode, input int budget);
        int           nb = 0;
        logic         held = 1'b0;
        logic [511:0] h_data = '0;
        logic         h_sop = 1'b0, h_eop = 1'b0;
        for (int c = 0; c < budget && nb < n; c++) begin
            host_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            if (held) begin
                check("stall_valid", 512'(host_valid), 512'(1));
                check("stall_data", host_data, h_data);
                check("stall_sop", 512'(host_sop), 512'(h_sop));
                check("stall_eop", 512'(host_eop), 512'(h_eop));
            end
            if (host_valid && host_ready) begin
                bd[nb] = host_data;
                bs[nb] = host_sop;
                be[nb] = host_eop;
                bc[nb] = c;
                nb++;
            end
            held   = host_valid && !host_ready;
            h_data = host_data;
            h_sop  = host_sop;
            h_eop  = host_eop;
            tick();
        end
        host_ready = 1'b1;
        if (nb < n) check("collect_timeout", 512'(nb), 512'(n));
    endtask

    task automatic check_pdu(input string tag, input int n, input int tag0);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, bd[i], pat(tag0 + i));
            check({tag, "_sop"}, 512'(bs[i]), 512'(i == 0));
            check({tag, "_eop"}, 512'(be[i]), 512'(i == n - 1));
        end
        check({tag, "_gapless"}, 512'(bc[n-1] - bc[0]), 512'(n - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        upd_valid = 1'b0; upd_size = '0; host_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 512'(host_valid), 512'(0));
        check("rst_base", 512'(base_addr), 512'(0));
        check("rst_af", 512'(almost_full), 512'(0));
        Rst_n = 1'b1;
        tick();
        check("rel_valid", 512'(host_valid), 512'(0));
        check("rel_cnt", 512'(pdu_cnt), 512'(0));

        // Basic 3-flit PDU with sop latency t+3
        for (int i = 0; i < 3; i++) write_slot(i, 'h100 + i);
        commit(3);
        check("t1_base", 512'(base_addr), 512'(3));
        check("t1_lat1", 512'(host_valid), 512'(0));
        tick();
        check("t1_lat2", 512'(host_valid), 512'(0));
        tick();
        check("t1_lat3_valid", 512'(host_valid), 512'(1));
        check("t1_lat3_sop", 512'(host_sop), 512'(1));
        collect(3, 0, 20);
        check_pdu("t1", 3, 'h100);
        check("t1_pdu_cnt", 512'(pdu_cnt), 512'(1));

        // almost_full: stalled 2-flit PDU fills the skid, then a 13-flit PDU leaves free=3
        host_ready = 1'b0;
        write_slot(3, 'h200);
        write_slot(4, 'h201);
        commit(2);
        repeat (4) tick();
        check("t2_af_low", 512'(almost_full), 512'(0));
        check("t2_stall_sop", 512'(host_sop), 512'(1));
        for (int i = 0; i < 13; i++) write_slot((5 + i) % 16, 'h300 + i);
        commit(13);
        repeat (3) tick();
        check("t2_af_high", 512'(almost_full), 512'(1));
        check("t2_stall_data", host_data, pat('h200));
        host_ready = 1'b1;
        check("t2_af_s0", 512'(almost_full), 512'(1));
        tick();
        check("t2_af_s1", 512'(almost_full), 512'(1));
        tick();
        check("t2_af_s2", 512'(almost_full), 512'(0));
        collect(13, 0, 40);
        check_pdu("t2b", 13, 'h300);
        check("t2_pdu_cnt", 512'(pdu_cnt), 512'(3));

        // Two 10-flit PDUs; the second wraps the slot index and the pointer
        for (int i = 0; i < 10; i++) write_slot(2 + i, 'h400 + i);
        commit(10);
        check("t3_base_a", 512'(base_addr), 512'(28));
        collect(10, 0, 40);
        check_pdu("t3a", 10, 'h400);
        for (int i = 0; i < 10; i++) write_slot((12 + i) % 16, 'h500 + i);
        commit(10);
        check("t3_base_b", 512'(base_addr), 512'(6));
        collect(10, 0, 40);
        check_pdu("t3b", 10, 'h500);
        check("t3_pdu_cnt", 512'(pdu_cnt), 512'(5));

        // Rejections: oversize update, zero-size update, write into a committed slot
        commit(20);
        check("t4_err_upd", 512'(err_cnt), 512'(1));
        check("t4_base_keep", 512'(base_addr), 512'(6));
        commit(0);
        tick();
        tick();
        check("t4_zero_err", 512'(err_cnt), 512'(1));
        check("t4_zero_base", 512'(base_addr), 512'(6));
        check("t4_zero_valid", 512'(host_valid), 512'(0));
        host_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_slot(6 + i, 'h600 + i);
        commit(4);
        repeat (5) tick();
        write_slot(9, 'h6FF);
        check("t4_err_wr", 512'(err_cnt), 512'(2));
        collect(4, 0, 40);
        check_pdu("t4", 4, 'h600);
        check("t4_pdu_cnt", 512'(pdu_cnt), 512'(6));

        // Back-to-back single-flit PDUs: stalled, then full rate
        host_ready = 1'b0;
        write_slot(10, 'h700);
        write_slot(11, 'h701);
        commit_two_singles();
        collect(2, 1, 40);
        for (int i = 0; i < 2; i++) begin
            check("t5a_data", bd[i], pat('h700 + i));
            check("t5a_sop", 512'(bs[i]), 512'(1));
            check("t5a_eop", 512'(be[i]), 512'(1));
        end
        write_slot(12, 'h702);
        write_slot(13, 'h703);
        commit_two_singles();
        collect(2, 0, 40);
        for (int i = 0; i < 2; i++) begin
            check("t5b_data", bd[i], pat('h702 + i));
            check("t5b_sop", 512'(bs[i]), 512'(1));
            check("t5b_eop", 512'(be[i]), 512'(1));
        end
        check("t5b_no_bubble", 512'(bc[1] - bc[0]), 512'(1));
        check("t5_pdu_cnt", 512'(pdu_cnt), 512'(10));
        check("t5_err_cnt", 512'(err_cnt), 512'(2));

        // Reset during beat 2 of a 5-flit PDU
        for (int i = 0; i < 5; i++) write_slot((14 + i) % 16, 'h800 + i);
        commit(5);
        collect(2, 0, 40);
        check("t6_pre_valid", 512'(host_valid), 512'(1));
        check("t6_pre_data", host_data, pat('h802));
        Rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 512'(host_valid), 512'(0));
        check("t6_rst_sop", 512'(host_sop), 512'(0));
        check("t6_rst_data", host_data, 512'(0));
        check("t6_rst_base", 512'(base_addr), 512'(0));
        check("t6_rst_af", 512'(almost_full), 512'(0));
        check("t6_rst_pdu", 512'(pdu_cnt), 512'(0));
        check("t6_rst_err", 512'(err_cnt), 512'(0));
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
        check("t6_rel_valid", 512'(host_valid), 512'(0));
        write_slot(0, 'h900);
        write_slot(1, 'h901);
        commit(2);
        check("t6_base", 512'(base_addr), 512'(2));
        collect(2, 0, 40);
        check_pdu("t6", 2, 'h900);
        check("t6_pdu_cnt", 512'(pdu_cnt), 512'(1));
        check("t6_err_cnt", 512'(err_cnt), 512'(0));
        check("t6_idle", 512'(host_valid), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_rb_responder.md
Name: pcie_rb_responder

Overview:
- Responder end of the PCIe ring-buffer write interface driven by the DMA block (pcie_rb_wr_*, pcie_rb_update_*, pcie_rb_wr_base_addr, pcie_rb_almost_full).
- Owns the ring storage and the committed-tail and read-head pointers, and applies backpressure.
- Drains committed PDUs in order as an SOP/EOP flit stream toward the host/CPU model.
- Used in rtl_sim as the host-side ring model and as the on-chip staging ring.

Parameters:
RB_AWIDTH, 12, log2 ring depth in flits (DEPTH = 2**RB_AWIDTH); must be <= PDU_AWIDTH
AF_THRESH, 32, pcie_rb_almost_full asserts when free flits <= AF_THRESH
SIZE_FIFO_DEPTH, 64, maximum committed-but-undrained PDUs

Ports:
Clk  in  1  single clock
Rst_n  in  1  reset, asynchronous, active-low
pcie_rb_wr_data  in  flit_lite_t  flit to store
pcie_rb_wr_addr  in  PDU_AWIDTH  absolute ring slot; low RB_AWIDTH bits used
pcie_rb_wr_en  in  1  write strobe
pcie_rb_wr_base_addr  out  PDU_AWIDTH  committed tail, zero-extended
pcie_rb_almost_full  out  1  registered backpressure
pcie_rb_update_valid  in  1  commit one PDU
pcie_rb_update_size  in  PDU_AWIDTH  PDU length in flits
host_data  out  512  drained flit
host_sop  out  1  first flit of PDU
host_eop  out  1  last flit of PDU
host_valid  out  1  flit valid
host_ready  in  1  consumer accepts
rb_pdu_cnt  out  32  PDUs delivered (eop handshakes)
rb_err_cnt  out  32  rejected writes plus rejected updates

Behaviour:
- Reset (async assert, sync release): all outputs 0; pointers, counters, size FIFO and FSM cleared. Mid-operation reset discards all PDUs and partial streams.
- Pointers tail and head are RB_AWIDTH+1 bits; wrap is natural modulo 2*DEPTH.
- used = tail - head; free = DEPTH - used; slot index = pointer[RB_AWIDTH-1:0].

Writes:
- Accepted iff slot offset (wr_addr - tail) mod DEPTH < free.
- Otherwise the write is dropped and rb_err_cnt increments by 1.
- No ordering is required among writes.

Updates (size S):
- S == 0: ignored, no error.
- S > free, or size FIFO full: rejected, rb_err_cnt increments by 1, tail unchanged.
- Otherwise: tail += S and S is pushed to the size FIFO.
- pcie_rb_wr_base_addr reflects the new tail on the next cycle.
- A write and an update in the same cycle: the write is checked against the pre-update tail.

almost_full:
- Registered: asserts when free <= AF_THRESH or the size FIFO has <= 1 free entry.
- Deasserts the cycle after free rises above the threshold.

Drain FSM:
- IDLE: if the size FIFO is non-empty, pop it into rem (PDU_AWIDTH bits), set first = 1, go to STREAM.
- STREAM:
  - Each cycle the 2-entry output skid buffer has space, issue a RAM read at head, then head++ and rem--.
  - Set sop on the first read and eop when rem == 1.
  - After the eop read, go to IDLE; if the size FIFO is non-empty, pop it directly and stay in STREAM (zero bubbles).
- The RAM has 1-cycle read latency and the skid buffer sits at the host port.
- host_* are held stable while host_valid & !host_ready.
- Space is reclaimed at RAM read, not at host handshake. The skid buffer keeps this safe because reclaimed slots are never re-read.
- Latency: update at cycle t gives host_valid with sop at t+3 when idle and host_ready = 1.
- Throughput: 1 flit per cycle sustained.
- Update and pop in the same cycle: both take effect; FIFO occupancy is unchanged.
- Single-flit PDU: sop = eop = 1 on the same beat.
- Counters wrap at 2**32.

Decomposition:
- Shared package: RB_AWIDTH default, rb_state_t enum {IDLE, STREAM}, rb_ptr_t typedef.
- flit_lite_t and PDU_AWIDTH stay in struct_s.
- Sub-module pcie_rb_ram: simple dual-port RAM, 1 write port, 1 read port, 1-cycle registered read, no read-during-write bypass needed.
- The size FIFO is a unified_fifo instance.

Test Plan:
- RB_AWIDTH=4: write slots 0..2, update S=3 -> base_addr=3 next cycle; host gets 3 beats, sop on beat 0, eop on beat 2, data matches; rb_pdu_cnt=1.
- Fill 13 flits with AF_THRESH=3 -> almost_full=1 once free<=3; drain 1 PDU -> almost_full=0 one cycle after free>3.
- Commit PDUs to wrap tail past 15 (sizes 10 then 10) -> second PDU slots 10..3 delivered in order; head/tail wrap with no gap.
- Update S=20 with free=16 -> rejected, rb_err_cnt=1, base_addr unchanged; write to an already committed slot -> dropped, rb_err_cnt=2.
- Two back-to-back S=1 updates with host_ready toggling 1/0 -> two sop=eop beats, data stable while stalled, zero inter-PDU bubble when ready=1.
- Assert Rst_n=0 mid-PDU (beat 2 of 5) -> all outputs 0 immediately; after release, a new S=2 PDU from slot 0 is delivered cleanly.
